// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scanner
// Purpose  : Time-multiplexed driver for a six-digit common-anode seven-segment
//            display (HH:MM:SS). A prescaler divides clk into digit slots.
//            At the end of every full scan the six input patterns are captured
//            together into a frame buffer. Every displayed frame therefore
//            comes from one coherent snapshot of the inputs.
// Ports    : clk          - single clock, rising edge
//            rst          - asynchronous reset, active low
//            seven_*_p1/2 - active-high {g..a} patterns (p1 tens, p2 units)
//            seg_n        - active-low segment bus {g..a}
//            an_n         - active-low digit enables, bit k = slot k
//            frame_start  - one-cycle pulse when a new snapshot is shown
// Options  : GHOST_BLANK_EN - when defined, the first DEAD cycles of every
//            slot are blanked to suppress ghosting between digits.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scanner #(
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seven_sec_p1,
  input  logic [6:0] seven_sec_p2,
  input  logic [6:0] seven_min_p1,
  input  logic [6:0] seven_min_p2,
  input  logic [6:0] seven_hr_p1,
  input  logic [6:0] seven_hr_p2,
  output logic [6:0] seg_n,
  output logic [5:0] an_n,
  output logic       frame_start
);

  localparam int                  c_tick_w    = $clog2(PRESCALE);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(PRESCALE - 1);
  localparam logic [2:0]          c_idx_last  = 3'd5;

  // --------------------------------------------------------------------------
  // Prescaler and slot index
  // --------------------------------------------------------------------------
  logic [c_tick_w-1:0] r_tick_cnt;
  logic [c_tick_w-1:0] w_tick_nxt;
  logic [2:0]          r_idx;
  logic                w_tick_wrap;
  logic                w_frame_wrap;

  assign w_tick_wrap  = (r_tick_cnt == c_tick_last);
  assign w_frame_wrap = w_tick_wrap && (r_idx == c_idx_last);
  assign w_tick_nxt   = w_tick_wrap ? '0 : r_tick_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
      r_idx      <= 3'd0;
    end else begin
      r_tick_cnt <= w_tick_nxt;
      if (w_tick_wrap) begin
        r_idx <= w_frame_wrap ? 3'd0 : r_idx + 3'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame buffer: all six digits are captured on the same edge, the one that
  // takes the scan from slot 5 back to slot 0. Live inputs never reach the
  // segment bus directly.
  // --------------------------------------------------------------------------
  logic [6:0] r_frame [6];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++) begin
        r_frame[i] <= 7'h00;
      end
    end else if (w_frame_wrap) begin
      r_frame[0] <= seven_sec_p2;
      r_frame[1] <= seven_sec_p1;
      r_frame[2] <= seven_min_p2;
      r_frame[3] <= seven_min_p1;
      r_frame[4] <= seven_hr_p2;
      r_frame[5] <= seven_hr_p1;
    end
  end

  // Explicit mux keeps the unused index codes 6 and 7 well defined.
  logic [6:0] w_pattern;

  always_comb begin
    w_pattern = 7'h00;
    case (r_idx)
      3'd0:    w_pattern = r_frame[0];
      3'd1:    w_pattern = r_frame[1];
      3'd2:    w_pattern = r_frame[2];
      3'd3:    w_pattern = r_frame[3];
      3'd4:    w_pattern = r_frame[4];
      3'd5:    w_pattern = r_frame[5];
      default: w_pattern = 7'h00;
    endcase
  end

  // --------------------------------------------------------------------------
  // SHOW/BLANK control
  // --------------------------------------------------------------------------
  logic w_blank;

`ifdef GHOST_BLANK_EN
  localparam logic [c_tick_w-1:0] c_dead = c_tick_w'(DEAD);

  typedef enum logic [0:0] {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_SHOW;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The decision uses the next tick value, so r_state always matches the
  // tick_cnt value held alongside it.
  always_comb begin
    w_state_nxt = ST_SHOW;
    if (w_tick_nxt < c_dead) begin
      w_state_nxt = ST_BLANK;
    end
  end

  assign w_blank = (r_state == ST_BLANK);
`else
  // Without dead-time blanking every slot is lit for all of its cycles.
  logic w_unused_dead;

  assign w_unused_dead = (DEAD != 0);
  assign w_blank       = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Registered outputs, one cycle behind idx, tick_cnt and the buffer.
  // --------------------------------------------------------------------------
  logic [6:0] w_seg_nxt;
  logic [5:0] w_an_nxt;

  always_comb begin
    w_seg_nxt = 7'h7F;
    w_an_nxt  = 6'h3F;
    if (!w_blank) begin
      w_an_nxt  = ~(6'b000001 << r_idx);
      w_seg_nxt = ~w_pattern;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_n       <= 7'h7F;
      an_n        <= 6'h3F;
      frame_start <= 1'b0;
    end else begin
      seg_n       <= w_seg_nxt;
      an_n        <= w_an_nxt;
      frame_start <= w_frame_wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scanner
// Purpose  : Self-checking bench for seven_seg_scanner (PRESCALE=4, DEAD=1).
//            A cycle model pushes the expected outputs at each rising edge.
//            The test tasks pop those values on the falling edge and compare
//            them with the DUT. The tasks also check hand-derived constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scanner;

  localparam int PRESCALE = 4;
  localparam int DEAD     = 1;
`ifdef GHOST_BLANK_EN
  localparam bit c_ghost = 1'b1;
`else
  localparam bit c_ghost = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seven_sec_p1, seven_sec_p2, seven_min_p1;
  logic [6:0] seven_min_p2, seven_hr_p1, seven_hr_p2;
  logic [6:0] seg_n;
  logic [5:0] an_n;
  logic       frame_start;

  seven_seg_scanner #(.PRESCALE(PRESCALE), .DEAD(DEAD)) dut (
    .clk          (clk),
    .rst          (rst),
    .seven_sec_p1 (seven_sec_p1),
    .seven_sec_p2 (seven_sec_p2),
    .seven_min_p1 (seven_min_p1),
    .seven_min_p2 (seven_min_p2),
    .seven_hr_p1  (seven_hr_p1),
    .seven_hr_p2  (seven_hr_p2),
    .seg_n        (seg_n),
    .an_n         (an_n),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  exp_t       sb [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [5:0] walk [6];

  // --------------------------------------------------------------------------
  // Reference model of the scanner: its outputs follow the model state by
  // one cycle.
  // --------------------------------------------------------------------------
  int         m_tick;
  int         m_idx;
  logic [6:0] m_buf [6];
  logic       m_blank;
  exp_t       m_e;
  bit         m_wrap;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tick  = 0;
      m_idx   = 0;
      m_blank = 1'b0;
      for (int i = 0; i < 6; i++) m_buf[i] = 7'h00;
      sb.delete();
    end else begin
      m_e.an  = m_blank ? 6'h3F : ~(6'b000001 << m_idx);
      m_e.seg = m_blank ? 7'h7F : ~m_buf[m_idx];
      m_wrap  = (m_tick == PRESCALE - 1);
      m_e.fs  = m_wrap && (m_idx == 5);
      sb.push_back(m_e);
      if (m_e.fs) begin
        m_buf[0] = seven_sec_p2;
        m_buf[1] = seven_sec_p1;
        m_buf[2] = seven_min_p2;
        m_buf[3] = seven_min_p1;
        m_buf[4] = seven_hr_p2;
        m_buf[5] = seven_hr_p1;
      end
      m_tick = m_wrap ? 0 : m_tick + 1;
      if (m_wrap) m_idx = (m_idx + 1) % 6;
      if (c_ghost) m_blank = (m_tick < DEAD);
    end
  end

  // Lit-cycle rule for explicit checks, with cyc counted from reset release.
  // With ghost blanking, the first cycle of each slot is dark. The only
  // exception is the very first slot after reset, because the control state
  // resets to SHOW.
  function automatic bit lit(input int c);
    return !(c_ghost && (c != 1) && (((c - 1) % PRESCALE) == 0));
  endfunction

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (seg_n !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_seg got=%h exp=7f", seg_n);
    end
    n_checks++;
    if (an_n !== 6'h3F) begin
      n_fail++;
      $display("FAIL reset_an got=%h exp=3f", an_n);
    end
    n_checks++;
    if (frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fs got=%b exp=0", frame_start);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_first_frame();
    exp_t e;
    exp_t x;
    rst = 1'b1;
    cyc = 0;
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      cyc++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL first_sb cyc=%0d got=empty exp=entry", cyc);
      end else begin
        e = sb.pop_front();
        if ({an_n, seg_n, frame_start} !== e) begin
          n_fail++;
          $display("FAIL first_sb cyc=%0d got an=%h seg=%h fs=%b exp an=%h seg=%h fs=%b",
                   cyc, an_n, seg_n, frame_start, e.an, e.seg, e.fs);
        end
      end
      x.an  = (cyc <= 24) ? walk[(cyc - 1) / 4] : 6'h3E;
      x.seg = (cyc <= 24) ? 7'h7F : 7'h40;
      x.fs  = (cyc == 24);
      if (!lit(cyc)) begin
        x.an  = 6'h3F;
        x.seg = 7'h7F;
      end
      n_checks++;
      if ({an_n, seg_n, frame_start} !== x) begin
        n_fail++;
        $display("FAIL first_walk cyc=%0d got an=%h seg=%h fs=%b exp an=%h seg=%h fs=%b",
                 cyc, an_n, seg_n, frame_start, x.an, x.seg, x.fs);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_midframe_change();
    exp_t e;
    exp_t x;
    int   slot;
    while (cyc < 72) begin
      @(negedge clk);
      cyc++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL mid_sb cyc=%0d got=empty exp=entry", cyc);
      end else begin
        e = sb.pop_front();
        if ({an_n, seg_n, frame_start} !== e) begin
          n_fail++;
          $display("FAIL mid_sb cyc=%0d got an=%h seg=%h fs=%b exp an=%h seg=%h fs=%b",
                   cyc, an_n, seg_n, frame_start, e.an, e.seg, e.fs);
        end
      end
      slot  = ((cyc - 1) / 4) % 6;
      x.an  = walk[slot];
      x.seg = 7'h40;
      if (cyc > 48 && slot == 2) x.seg = 7'h79;
      if (cyc > 48 && slot == 5) x.seg = 7'h7F;
      x.fs  = ((cyc % 24) == 0);
      if (!lit(cyc)) begin
        x.an  = 6'h3F;
        x.seg = 7'h7F;
      end
      n_checks++;
      if ({an_n, seg_n, frame_start} !== x) begin
        n_fail++;
        $display("FAIL mid_frame cyc=%0d got an=%h seg=%h fs=%b exp an=%h seg=%h fs=%b",
                 cyc, an_n, seg_n, frame_start, x.an, x.seg, x.fs);
      end
      // The scan is in slot 3 here. The new values must wait for the next
      // frame wrap.
      if (cyc == 37) begin
        seven_min_p2 = 7'h06;
        seven_hr_p1  = 7'h00;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_async_reset();
    exp_t e;
    while (cyc < 90) begin
      @(negedge clk);
      cyc++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL ar_sb cyc=%0d got=empty exp=entry", cyc);
      end else begin
        e = sb.pop_front();
        if ({an_n, seg_n, frame_start} !== e) begin
          n_fail++;
          $display("FAIL ar_sb cyc=%0d got an=%h seg=%h fs=%b exp an=%h seg=%h fs=%b",
                   cyc, an_n, seg_n, frame_start, e.an, e.seg, e.fs);
        end
      end
    end
    n_checks++;
    if (an_n !== 6'h2F || seg_n !== 7'h40) begin
      n_fail++;
      $display("FAIL ar_slot4 got an=%h seg=%h exp an=2f seg=40", an_n, seg_n);
    end
    // Assert reset between clock edges. The outputs must clear before the
    // next rising edge.
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (seg_n !== 7'h7F) begin
      n_fail++;
      $display("FAIL ar_seg got=%h exp=7f", seg_n);
    end
    n_checks++;
    if (an_n !== 6'h3F) begin
      n_fail++;
      $display("FAIL ar_an got=%h exp=3f", an_n);
    end
    n_checks++;
    if (frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_fs got=%b exp=0", frame_start);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cyc++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL ar_restart_sb cyc=%0d got=empty exp=entry", cyc);
      end else begin
        e = sb.pop_front();
        if ({an_n, seg_n, frame_start} !== e) begin
          n_fail++;
          $display("FAIL ar_restart_sb cyc=%0d got an=%h seg=%h fs=%b exp an=%h seg=%h fs=%b",
                   cyc, an_n, seg_n, frame_start, e.an, e.seg, e.fs);
        end
      end
      n_checks++;
      if (an_n !== (lit(cyc) ? 6'h3E : 6'h3F) || seg_n !== 7'h7F) begin
        n_fail++;
        $display("FAIL ar_restart cyc=%0d got an=%h seg=%h exp an=%h seg=7f",
                 cyc, an_n, seg_n, lit(cyc) ? 6'h3E : 6'h3F);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_frames();
    exp_t e;
    int   pulses = 0;
    int   last   = -1;
    int   viol   = 0;
    while (cyc < 80) begin
      @(negedge clk);
      cyc++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL frames_sb cyc=%0d got=empty exp=entry", cyc);
      end else begin
        e = sb.pop_front();
        if ({an_n, seg_n, frame_start} !== e) begin
          n_fail++;
          $display("FAIL frames_sb cyc=%0d got an=%h seg=%h fs=%b exp an=%h seg=%h fs=%b",
                   cyc, an_n, seg_n, frame_start, e.an, e.seg, e.fs);
        end
      end
      if ($countones(~an_n) > 1) viol++;
      if (frame_start === 1'b1) begin
        pulses++;
        if (last >= 0) begin
          n_checks++;
          if (cyc - last !== 24) begin
            n_fail++;
            $display("FAIL frames_period cyc=%0d got=%0d exp=24", cyc, cyc - last);
          end
        end
        last = cyc;
      end
    end
    n_checks++;
    if (pulses !== 3) begin
      n_fail++;
      $display("FAIL frames_pulses got=%0d exp=3", pulses);
    end
    n_checks++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL frames_onehot got=%0d exp=0", viol);
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    walk = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    rst          = 1'b0;
    seven_sec_p1 = 7'h3F;
    seven_sec_p2 = 7'h3F;
    seven_min_p1 = 7'h3F;
    seven_min_p2 = 7'h3F;
    seven_hr_p1  = 7'h3F;
    seven_hr_p2  = 7'h3F;
    test_reset();
    test_first_frame();
    test_midframe_change();
    test_async_reset();
    test_frames();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
